mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STREAK_MAX, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  fetch request strobe
- i_ready  out  1  fetch request accepted this cycle
- i_addr  in  32  fetch address
- i_data  out  32  fetch read data
- i_data_valid  out  1  fetch response strobe
- d_start  in  1  data request strobe
- d_ready  out  1  data request accepted this cycle
- d_addr  in  32  data address
- d_wen  in  1  1 = write, 0 = read
- d_wdata  in  32  write data
- d_wmask  in  4  byte-write enables
- d_data  out  32  data read data
- d_data_valid  out  1  data response strobe (reads and writes)
- mem_start  out  1  request to memory
- mem_ready  in  1  memory can accept a request
- mem_addr  out  32  memory address
- mem_wen  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte enables
- mem_data  in  32  memory read data
- mem_data_valid  in  1  memory response strobe

Function
REQ-003 SHALL share one memory port between fetch (I) and data (D), with at most one outstanding memory request.
REQ-004 SHALL implement states IDLE and BUSY, with owner register OWN in {I, D}.
REQ-005 Slot open SHALL mean state==IDLE, or state==BUSY && mem_data_valid; this permits back-to-back requests with zero bubble.
REQ-006 Grant SHALL be combinational:
- only d_start: D
- only i_start: I
- both: D unless streak==STREAK_MAX, then I
REQ-007 mem_start SHALL equal slot open && granted requester's start; mem_addr/mem_wen/mem_wdata/mem_wmask SHALL mux from the granted requester.
- I grant: mem_wen=0, mem_wmask=0.
- No grant: address/data mux selects D, mem_wen=0.
REQ-008 i_ready (d_ready) SHALL be 1 only when mem_start && mem_ready && grant==I (D); acceptance = start && ready in the same cycle.
REQ-009 On acceptance: state SHALL go to BUSY and OWN to the grantee at the next edge. If the slot opened via mem_data_valid but nothing is accepted, state SHALL go to IDLE.
REQ-010 mem_data_valid in BUSY SHALL be routed to i_data_valid or d_data_valid by OWN (owner at time of issue, before any same-cycle update).
- i_data = d_data = mem_data, unconditionally.
- mem_data_valid in IDLE SHALL be ignored.
REQ-011 Streak counter (saturating at STREAK_MAX) SHALL be updated only on acceptance:
- D accepted while i_start=1: increment.
- I accepted, or D accepted with i_start=0: clear.
REQ-012 Requesters SHALL hold start/addr/data until ready. start SHALL NOT depend combinationally on ready. A requester withdrawing start before acceptance SHALL be legal and have no side effect.
REQ-013 Latency: request to mem_start = 0 cycles; mem_data_valid to requester valid = 0 cycles.
REQ-014 A start arriving while BUSY without mem_data_valid SHALL see ready=0 and SHALL NOT reach the memory.

Reset
REQ-015 On reset=1, asynchronously:
- state=IDLE, OWN=D, streak=0.
- i_ready, d_ready, mem_start, i_data_valid, d_data_valid SHALL all be 0 while reset is high, regardless of other inputs.
REQ-016 Reset mid-transaction SHALL discard the outstanding request. A later mem_data_valid arriving in IDLE SHALL be ignored per REQ-010.

Structure
REQ-017 The owner enum {OWN_I, OWN_D}, state enum {IDLE, BUSY} and default STREAK_MAX SHALL live in shared package mem_arb_pkg.
REQ-018 Grant logic (REQ-006) SHALL be sub-module mem_arb_select (inputs i_start, d_start, streak; output grant); everything else stays in mem_arbiter.

Verification
REQ-019 Single fetch: i_start, i_addr=0x100, mem_ready=1 -> same cycle mem_start=1, mem_addr=0x100, i_ready=1. mem_data_valid two cycles later with 0x00000013 -> i_data_valid=1, i_data=0x13, d_data_valid=0.
REQ-020 Simultaneous requests: i_start and d_start (d_wen=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=0xF) in IDLE -> D granted, mem_wen=1. I is granted in the same cycle as the D mem_data_valid.
REQ-021 Starvation: d_start and i_start held constantly, mem response 1 cycle -> exactly 4 D grants, then 1 I grant, then the pattern repeats.
REQ-022 Busy blocking: start held while BUSY with mem_data_valid=0 -> mem_start=0, ready=0 for every such cycle.
REQ-023 Reset mid-transaction: reset during BUSY(I), then mem_data_valid after reset release -> no i_data_valid, no d_data_valid, state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the fetch/data memory arbiter
package mem_arb_pkg;
  typedef enum logic {OWN_I, OWN_D} own_e;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam int STREAK_MAX_DEF = 4;
  localparam int STREAK_W = 8;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational grant, data wins unless fetch has waited out a full streak
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic                i_start,
  input  logic                d_start,
  input  logic [STREAK_W-1:0] streak,
  output own_e                grant
);
  assign grant = (i_start && (!d_start || streak == STREAK_W'(STREAK_MAX))) ? OWN_I : OWN_D;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data with one request outstanding
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_data_valid,
  input  logic        d_start,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic        d_wen,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_data,
  output logic        d_data_valid,
  output logic        mem_start,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_data,
  input  logic        mem_data_valid
);
  state_e              state_q, state_d;
  own_e                own_q, own_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  own_e                grant;
  logic                slot_open, acc;

  mem_arb_select #(.STREAK_MAX(STREAK_MAX)) u_sel (
    .i_start(i_start),
    .d_start(d_start),
    .streak (streak_q),
    .grant  (grant)
  );

  // Issue path, response routing by the owner at issue time, and next-state
  always_comb begin
    slot_open    = state_q == IDLE || mem_data_valid;
    mem_start    = !reset && slot_open && (grant == OWN_I ? i_start : d_start);
    acc          = mem_start && mem_ready;
    i_ready      = acc && grant == OWN_I;
    d_ready      = acc && grant == OWN_D;
    mem_addr     = grant == OWN_I ? i_addr : d_addr;
    mem_wen      = grant == OWN_D && d_start && d_wen;
    mem_wdata    = d_wdata;
    mem_wmask    = grant == OWN_I ? 4'h0 : d_wmask;
    i_data_valid = state_q == BUSY && mem_data_valid && own_q == OWN_I;
    d_data_valid = state_q == BUSY && mem_data_valid && own_q == OWN_D;
    i_data       = mem_data;
    d_data       = mem_data;
    state_d      = acc ? BUSY : slot_open ? IDLE : state_q;
    own_d        = acc ? grant : own_q;
    streak_d     = !acc ? streak_q :
                   (grant == OWN_I || !i_start) ? '0 :
                   streak_q == STREAK_W'(STREAK_MAX) ? streak_q : streak_q + 1'b1;
  end

  // State, owner and streak registers; reset drops any outstanding request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      own_q    <= OWN_D;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      streak_q <= streak_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus response scoreboard for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, reset;
  logic        i_start, i_ready, i_data_valid;
  logic [31:0] i_addr, i_data;
  logic        d_start, d_ready, d_wen, d_data_valid;
  logic [31:0] d_addr, d_wdata, d_data;
  logic [3:0]  d_wmask;
  logic        mem_start, mem_ready, mem_wen, mem_data_valid;
  logic [31:0] mem_addr, mem_wdata, mem_data;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.STREAK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_ready(i_ready), .i_addr(i_addr), .i_data(i_data), .i_data_valid(i_data_valid),
    .d_start(d_start), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_data(d_data), .d_data_valid(d_data_valid),
    .mem_start(mem_start), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_data(mem_data), .mem_data_valid(mem_data_valid)
  );

  int checks = 0, errors = 0;

  typedef struct packed {logic is_i; logic [31:0] data;} exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic is, ds, rdy, wen;
    logic e_ms, e_ir, e_dr, e_seli, e_wen;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    i_start = 0;
    d_start = 0;
    mem_data_valid = 0;
  endtask

  task automatic push(input logic is_i, input logic [31:0] data);
    sb.push_back('{is_i, data});
  endtask

  task automatic resp_drive(output exp_t e);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty t=%0t", $time);
      e = '0;
    end else e = sb.pop_front();
    mem_data_valid = 1;
    mem_data = e.data;
  endtask

  task automatic resp_check(input exp_t e);
    chk("i_data_valid", {31'b0, i_data_valid}, {31'b0, e.is_i});
    chk("d_data_valid", {31'b0, d_data_valid}, {31'b0, !e.is_i});
    chk("resp_data", e.is_i ? i_data : d_data, e.data);
  endtask

  initial begin
    exp_t e;
    logic ei;
    tbl[0] = '{1, 0, 1, 0, 1, 1, 0, 1, 0};
    tbl[1] = '{0, 1, 1, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 1, 1, 1, 0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 1, 0, 1, 0, 1};
    tbl[4] = '{1, 1, 0, 1, 1, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 0, 1, 0, 0, 1, 0};
    reset = 1; i_start = 1; d_start = 1; mem_ready = 1; mem_data_valid = 1;
    i_addr = 0; d_addr = 0; d_wen = 1; d_wdata = 0; d_wmask = 4'hF; mem_data = 32'h55;
    #3;
    chk("rst_mem_start", {31'b0, mem_start}, 0);
    chk("rst_i_ready", {31'b0, i_ready}, 0);
    chk("rst_d_ready", {31'b0, d_ready}, 0);
    chk("rst_i_dv", {31'b0, i_data_valid}, 0);
    chk("rst_d_dv", {31'b0, d_data_valid}, 0);
    cyc;
    reset = 0;
    idle_in;
    for (int k = 0; k < 7; k++) begin
      cyc;
      idle_in;
      i_start = tbl[k].is; d_start = tbl[k].ds; mem_ready = tbl[k].rdy; d_wen = tbl[k].wen;
      i_addr = 32'h100 + k * 4; d_addr = 32'h2000 + k * 8; d_wmask = 4'h3; d_wdata = $urandom;
      if (tbl[k].e_ir || tbl[k].e_dr) push(tbl[k].e_ir, $urandom);
      #2;
      chk("v_mem_start", {31'b0, mem_start}, {31'b0, tbl[k].e_ms});
      chk("v_i_ready", {31'b0, i_ready}, {31'b0, tbl[k].e_ir});
      chk("v_d_ready", {31'b0, d_ready}, {31'b0, tbl[k].e_dr});
      chk("v_mem_addr", mem_addr, tbl[k].e_seli ? i_addr : d_addr);
      chk("v_mem_wen", {31'b0, mem_wen}, {31'b0, tbl[k].e_wen});
      chk("v_mem_wmask", {28'b0, mem_wmask}, tbl[k].e_seli ? 32'h0 : {28'b0, d_wmask});
      chk("v_mem_wdata", mem_wdata, d_wdata);
      if (tbl[k].e_ir || tbl[k].e_dr) begin
        cyc;
        idle_in;
        resp_drive(e);
        #2;
        resp_check(e);
      end
    end
    // single fetch with response two cycles after issue
    cyc; idle_in;
    i_start = 1; i_addr = 32'h100; mem_ready = 1;
    push(1, 32'h13);
    #2;
    chk("f_mem_start", {31'b0, mem_start}, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_i_ready", {31'b0, i_ready}, 1);
    chk("f_d_ready", {31'b0, d_ready}, 0);
    cyc; i_start = 0;
    #2;
    chk("f_busy_mem_start", {31'b0, mem_start}, 0);
    cyc; resp_drive(e);
    #2;
    resp_check(e);
    // simultaneous requests, busy blocking, zero-bubble handoff to fetch
    cyc; idle_in;
    i_start = 1; d_start = 1; d_wen = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF; i_addr = 32'h300;
    push(0, $urandom);
    #2;
    chk("s_d_ready", {31'b0, d_ready}, 1);
    chk("s_i_ready", {31'b0, i_ready}, 0);
    chk("s_mem_wen", {31'b0, mem_wen}, 1);
    chk("s_mem_addr", mem_addr, 32'h2000);
    chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s_mem_wmask", {28'b0, mem_wmask}, 32'hF);
    cyc; d_start = 0;
    for (int b = 0; b < 2; b++) begin
      #2;
      chk("b_mem_start", {31'b0, mem_start}, 0);
      chk("b_i_ready", {31'b0, i_ready}, 0);
      cyc;
    end
    resp_drive(e);
    push(1, $urandom);
    #2;
    resp_check(e);
    chk("h_i_ready", {31'b0, i_ready}, 1);
    chk("h_mem_addr", mem_addr, 32'h300);
    chk("h_mem_wen", {31'b0, mem_wen}, 0);
    cyc; idle_in;
    resp_drive(e);
    #2;
    resp_check(e);
    // starvation: both held, one-cycle memory, expect D D D D I repeating
    cyc; idle_in;
    i_start = 1; d_start = 1; d_wen = 0; mem_ready = 1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) resp_drive(e);
      ei = (c % 5) == 4;
      push(ei, $urandom);
      #2;
      if (c > 0) resp_check(e);
      chk("st_i_ready", {31'b0, i_ready}, {31'b0, ei});
      chk("st_d_ready", {31'b0, d_ready}, {31'b0, !ei});
      cyc;
    end
    idle_in;
    resp_drive(e);
    #2;
    resp_check(e);
    // reset during a fetch, then a stale response must be ignored
    cyc; idle_in;
    i_start = 1; i_addr = 32'h400; mem_ready = 1;
    #2;
    chk("r_i_ready", {31'b0, i_ready}, 1);
    cyc;
    reset = 1; d_start = 1; mem_data_valid = 1; mem_data = 32'hBAD;
    #2;
    chk("r_mem_start", {31'b0, mem_start}, 0);
    chk("r_i_ready_rst", {31'b0, i_ready}, 0);
    chk("r_d_ready_rst", {31'b0, d_ready}, 0);
    chk("r_i_dv_rst", {31'b0, i_data_valid}, 0);
    chk("r_d_dv_rst", {31'b0, d_data_valid}, 0);
    cyc;
    reset = 0; i_start = 0; d_start = 0; mem_data_valid = 1;
    #2;
    chk("r_stale_i_dv", {31'b0, i_data_valid}, 0);
    chk("r_stale_d_dv", {31'b0, d_data_valid}, 0);
    cyc; idle_in;
    i_start = 1;
    push(1, $urandom);
    #2;
    chk("r_idle_mem_start", {31'b0, mem_start}, 1);
    chk("r_idle_i_ready", {31'b0, i_ready}, 1);
    cyc; idle_in;
    resp_drive(e);
    #2;
    resp_check(e);
    chk("sb_drained", sb.size(), 0);
    cyc; idle_in;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
